// File: rtl/matrix_pkg.sv
// Shared definitions for the input-matrix load path and register bank.
// Element geometry and the load controller state encoding.
package matrix_pkg;

  localparam int DATA_W = 8;
  localparam int DIM    = 8;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FULL  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/input_mat_load_ctrl.sv
// Streams one DIM x DIM matrix from the input RAM into the register bank,
// LANES elements per read, and holds it until the consumer releases it.
module input_mat_load_ctrl #(
  parameter int DATA_W = matrix_pkg::DATA_W,
  parameter int DIM    = matrix_pkg::DIM,
  parameter int LANES  = matrix_pkg::LANES,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    consume,
  output logic                    ram_rd_en,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic [LANES*DATA_W-1:0] ram_rdata,
  output logic                    wr_en,
  output logic [2:0]              bank_sel,
  output logic [2:0]              elem_sel,
  output logic [LANES*DATA_W-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    mat_valid
);

  import matrix_pkg::*;

  // Two reads per bank row, so the counter spans 2*DIM reads.
  localparam int CNT_W = $clog2(2 * DIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * DIM - 1);

  ld_state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (rd_cnt_q == CNT_LAST) state_d = DRAIN;
      DRAIN:   state_d = FULL;
      FULL:    if (consume) state_d = start ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_rd_en = (state_q == READ);
    busy      = (state_q == READ) || (state_q == DRAIN);
    mat_valid = (state_q == FULL);
    ram_addr  = base_q + ADDR_W'(rd_cnt_q);
    wr_en     = wr_en_q;
    bank_sel  = wr_cnt_q[CNT_W-1:1];
    elem_sel  = wr_cnt_q[0] ? 3'(LANES) : 3'd0;
    wr_data   = ram_rdata;
    done      = done_q;
  end

  // A new load may begin from IDLE, or from FULL in the same cycle as consume.
  always_comb begin
    accept   = start &&
               ((state_q == IDLE) || ((state_q == FULL) && consume));
    base_d   = accept ? base_addr : base_q;
    rd_cnt_d = rd_cnt_q;
    if (accept) begin
      rd_cnt_d = '0;
    end else if (state_q == READ) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    wr_en_d  = (state_q == READ);
    wr_cnt_d = rd_cnt_q;
    done_d   = (state_q == DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      wr_en_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      base_q   <= base_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      wr_en_q  <= wr_en_d;
      done_q   <= done_d;
    end
  end

endmodule
